// File: rtl/keycode_tracker_if.sv
// Event channel into the keycode tracker: one press/release/clear event per
// valid/ready handshake.
interface keycode_tracker_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_op;
  logic [7:0] ev_code;

  modport master (
    output ev_valid,
    output ev_op,
    output ev_code,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_op,
    input  ev_code,
    output ev_ready
  );
endinterface

// File: rtl/keycode_tracker.sv
// Held-key table for the character controllers: applies HID key events in press
// order and publishes the whole table as one coherent 32-bit word per frame tick.
module keycode_tracker #(
  parameter int         NUM_SLOTS = 4,
  parameter logic [7:0] NULL_CODE = 8'h00
) (
  input  logic                Clk,
  input  logic                Reset_n,
  keycode_tracker_if.slave    ev,
  input  logic                frame_tick,
  output logic [31:0]         keycode,
  output logic [2:0]          key_count,
  output logic                overflow
);

  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;

  localparam logic [1:0] OP_PRESS   = 2'b00;
  localparam logic [1:0] OP_RELEASE = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
  typedef logic [NUM_SLOTS-1:0][DATA_W-1:0] tbl_t;

  state_t state, state_nxt;

  tbl_t slot, slot_nxt;
  logic [2:0] count_nxt;
  logic       ovf_nxt;
  logic       pending;
  logic       accept;

  logic [1:0]        op_p0;
  logic [DATA_W-1:0] code_p0;

  logic [IDX_W-1:0] match_idx_p1;
  logic             hit_p1;
  logic [IDX_W-1:0] empty_idx_p1;
  logic             empty_vld_p1;

  logic [IDX_W:0] match_scan;
  logic [IDX_W:0] empty_scan;

  // Returns {found, index} of the lowest slot holding the given code.
  function automatic logic [IDX_W:0] first_equal(input tbl_t tbl, input logic [DATA_W-1:0] code);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (tbl[i] == code) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  assign ev.ev_ready = Reset_n && (state == IDLE);
  assign accept      = ev.ev_valid && ev.ev_ready;
  assign match_scan  = first_equal(slot, code_p0);
  assign empty_scan  = first_equal(slot, NULL_CODE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APPLY: table edit for the captured event; NULL codes never touch the table.
  always_comb begin
    slot_nxt  = slot;
    count_nxt = key_count;
    ovf_nxt   = overflow;
    if (state == APPLY) begin
      case (op_p0)
        OP_PRESS: begin
          if (code_p0 != NULL_CODE && !hit_p1) begin
            if (empty_vld_p1) begin
              slot_nxt[empty_idx_p1] = code_p0;
              count_nxt              = key_count + 3'd1;
            end else begin
              ovf_nxt = 1'b1;
            end
          end
        end
        OP_RELEASE: begin
          if (code_p0 != NULL_CODE && hit_p1) begin
            for (int j = 0; j < NUM_SLOTS - 1; j++) begin
              if (IDX_W'(j) >= match_idx_p1) slot_nxt[j] = slot[j+1];
            end
            slot_nxt[NUM_SLOTS-1] = NULL_CODE;
            count_nxt             = key_count - 3'd1;
          end
        end
        OP_CLEAR: begin
          slot_nxt  = {NUM_SLOTS{NULL_CODE}};
          count_nxt = 3'd0;
          ovf_nxt   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      slot      <= {NUM_SLOTS{NULL_CODE}};
      key_count <= 3'd0;
      overflow  <= 1'b0;
      keycode   <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      key_count <= count_nxt;
      overflow  <= ovf_nxt;
      // A tick seen mid-event is deferred so the published word includes that event.
      case (state)
        IDLE: if (frame_tick) keycode <= slot;
        SCAN: if (frame_tick) pending <= 1'b1;
        APPLY: begin
          if (frame_tick || pending) begin
            keycode <= slot_nxt;
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: event capture on acceptance
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_p0   <= ev.ev_op;
      code_p0 <= ev.ev_code;
    end
  end

  // Stage p1: table scan results, consumed in APPLY
  always_ff @(posedge Clk) begin
    if (state == SCAN) begin
      hit_p1       <= match_scan[IDX_W];
      match_idx_p1 <= match_scan[IDX_W-1:0];
      empty_vld_p1 <= empty_scan[IDX_W];
      empty_idx_p1 <= empty_scan[IDX_W-1:0];
    end
  end

endmodule

// File: tb/tb_keycode_tracker.sv
// Directed bench for keycode_tracker: a queue-based reference model of held keys
// feeds a scoreboard checked after each event and each frame tick.
module tb_keycode_tracker;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic [31:0] keycode;
  logic [2:0]  key_count;
  logic        overflow;

  keycode_tracker_if ev_if ();

  keycode_tracker dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ev         (ev_if),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .key_count  (key_count),
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  int tests  = 0;
  int failed = 0;

  logic [7:0]  m_keys[$];
  logic        m_ovf;
  logic [31:0] m_pub;

  logic [3:0]  st_q[$];
  logic [31:0] kc_q[$];

  function automatic logic [31:0] m_pack();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < m_keys.size(); i++) w[8*i +: 8] = m_keys[i];
    return w;
  endfunction

  function automatic void m_apply(input logic [1:0] op, input logic [7:0] code);
    int idx;
    idx = -1;
    for (int i = 0; i < m_keys.size(); i++) if (m_keys[i] == code) idx = i;
    case (op)
      2'b00: if (code != 8'h00 && idx < 0) begin
        if (m_keys.size() < 4) m_keys.push_back(code);
        else m_ovf = 1'b1;
      end
      2'b01: if (code != 8'h00 && idx >= 0) m_keys.delete(idx);
      2'b10: begin
        m_keys.delete();
        m_ovf = 1'b0;
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // tick_at: 0 none, 1 on the accept edge, 2 during SCAN, 3 during APPLY
  task automatic send_event(input logic [1:0] op, input logic [7:0] code, input int tick_at);
    logic [31:0] pre, old_pub, hold;
    logic [3:0]  st;
    logic [31:0] kexp;
    @(negedge Clk);
    chk("ready_idle", {31'd0, ev_if.ev_ready}, 32'd1);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_op    = op;
    ev_if.ev_code  = code;
    frame_tick     = (tick_at == 1);
    old_pub = m_pub;
    pre     = m_pack();
    m_apply(op, code);
    if (tick_at == 1) m_pub = pre;
    else if (tick_at >= 2) m_pub = m_pack();
    st_q.push_back({3'(m_keys.size()), m_ovf});
    kc_q.push_back(m_pub);
    hold = (tick_at == 1) ? pre : old_pub;
    @(negedge Clk);
    ev_if.ev_valid = 1'b0;
    ev_if.ev_op    = 2'($urandom);
    ev_if.ev_code  = 8'($urandom);
    frame_tick     = (tick_at == 2);
    chk("ready_scan", {31'd0, ev_if.ev_ready}, 32'd0);
    chk("keycode_scan", keycode, hold);
    @(negedge Clk);
    frame_tick = (tick_at == 3);
    chk("ready_apply", {31'd0, ev_if.ev_ready}, 32'd0);
    chk("keycode_apply", keycode, hold);
    @(negedge Clk);
    frame_tick = 1'b0;
    chk("ready_back", {31'd0, ev_if.ev_ready}, 32'd1);
    st   = st_q.pop_front();
    kexp = kc_q.pop_front();
    chk("key_count", {29'd0, key_count}, {29'd0, st[3:1]});
    chk("overflow", {31'd0, overflow}, {31'd0, st[0]});
    chk("keycode_after", keycode, kexp);
  endtask

  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    m_pub = m_pack();
    kc_q.push_back(m_pub);
    @(negedge Clk);
    frame_tick = 1'b0;
    chk("tick_pub", keycode, kc_q.pop_front());
  endtask

  initial begin
    Reset_n        = 1'b0;
    frame_tick     = 1'b0;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_op    = 2'b00;
    ev_if.ev_code  = 8'h00;
    m_ovf = 1'b0;
    m_pub = '0;
    repeat (3) @(negedge Clk);
    chk("ready_in_reset", {31'd0, ev_if.ev_ready}, 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("reset_ready", {31'd0, ev_if.ev_ready}, 32'd1);
    chk("reset_keycode", keycode, 32'd0);
    chk("reset_count", {29'd0, key_count}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);

    send_event(2'b00, 8'h50, 0); tick();
    send_event(2'b00, 8'h4F, 0); tick();
    send_event(2'b00, 8'h52, 0); tick();
    chk("three_keys", keycode, 32'h00524F50);

    send_event(2'b11, 8'h55, 0);
    send_event(2'b00, 8'h00, 0);
    send_event(2'b01, 8'h00, 0);
    tick();
    chk("reserved_null_noop", keycode, 32'h00524F50);

    send_event(2'b10, 8'h00, 0); tick();
    send_event(2'b00, 8'h04, 0);
    send_event(2'b00, 8'h07, 0);
    send_event(2'b00, 8'h1A, 0);
    send_event(2'b00, 8'h16, 0);
    send_event(2'b00, 8'h2C, 0);
    tick();
    chk("full_word", keycode, 32'h161A0704);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    send_event(2'b00, 8'h07, 0); tick();

    send_event(2'b01, 8'h07, 0); tick();
    chk("release_compact", keycode, 32'h00161A04);
    send_event(2'b01, 8'h99, 0); tick();
    chk("release_miss_ovf", {31'd0, overflow}, 32'd1);

    send_event(2'b10, 8'h00, 0);
    chk("clear_unpublished", keycode, 32'h00161A04);
    tick();
    chk("clear_published", keycode, 32'h00000000);

    send_event(2'b00, 8'h50, 2);
    chk("deferred_pub", keycode, 32'h00000050);
    send_event(2'b00, 8'h51, 1);
    send_event(2'b00, 8'h52, 3);
    send_event(2'b01, 8'h51, 0); tick();

    send_event(2'b10, 8'h00, 0);
    send_event(2'b00, 8'h10, 0);
    send_event(2'b00, 8'h11, 0);
    tick();
    @(negedge Clk);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_op    = 2'b00;
    ev_if.ev_code  = 8'h12;
    @(negedge Clk);
    ev_if.ev_valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("ready_reset_apply", {31'd0, ev_if.ev_ready}, 32'd0);
    Reset_n = 1'b1;
    #1;
    m_keys.delete();
    m_ovf = 1'b0;
    m_pub = '0;
    chk("rst_apply_keycode", keycode, 32'd0);
    chk("rst_apply_count", {29'd0, key_count}, 32'd0);
    chk("rst_apply_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_apply_ready", {31'd0, ev_if.ev_ready}, 32'd1);

    send_event(2'b00, 8'h2A, 0); tick();
    chk("post_reset_press", keycode, 32'h0000002A);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/keycode_tracker.md
Name: keycode_tracker

Overview:
- Producer of the packed 32-bit `keycode` word that the character controllers consume.
- Accepts discrete key press/release/clear events from the USB HID event path over a valid/ready handshake.
- Keeps a 4-slot table of held keys in press order, compacts the table on release, and publishes it as one coherent word on each frame tick, so consumers on frame_clk never see a half-updated table.

Parameters:
- NUM_SLOTS, 4, number of held-key slots. Fixed at 4 to match the 32-bit keycode word; other values unsupported.
- NULL_CODE, 8'h00, code meaning "empty slot". Press/release events carrying it are accepted and ignored.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset_n  in  1  synchronous, active-low reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event this cycle.
- ev_op  in  2  event opcode: 00 press, 01 release, 10 clear-all, 11 reserved.
- ev_code  in  8  HID usage code for press/release; ignored for clear/reserved.
- frame_tick  in  1  one-cycle publish request, synchronised to Clk.
- keycode  out  32  published table: slot0 in [7:0] (oldest) through slot3 in [31:24] (newest).
- key_count  out  3  number of occupied slots in the internal table (0..4).
- overflow  out  1  sticky: a press was dropped because the table was full.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - Table, keycode, key_count, overflow and publish-pending all return to 0; FSM goes to IDLE.
  - Any in-flight event is discarded.
  - ev_ready reads 0 during reset and 1 in the first cycle after release.
- Handshake:
  - An event is accepted on a cycle where ev_valid=1, ev_ready=1 and the FSM is in IDLE.
  - ev_ready=1 only in IDLE.
  - ev_op and ev_code are captured on acceptance; the source may change them afterwards.
- FSM IDLE -> SCAN -> APPLY -> IDLE. With acceptance at edge T:
  - SCAN at T+1: registers match_idx (first slot equal to the code), the hit flag, and empty_idx (first NULL slot).
  - APPLY at T+2: writes the table and key_count.
  - IDLE with ev_ready=1 at T+3. Throughput is one event per 3 cycles.
- Press:
  - Code already held (hit): no change.
  - Otherwise, if key_count<4: write the code to slot[key_count] and increment key_count.
  - Otherwise (table full): drop the event and set overflow=1.
- Release:
  - On hit at index i: shift slot[j]=slot[j+1] for j>=i, set slot3=0, decrement key_count.
  - On miss: no change, overflow unaffected.
- Clear-all: all slots 0, key_count 0, overflow 0.
- Reserved opcode 11: accepted, full 3-cycle pass, no state change.
- NULL_CODE press/release: no state change.
- Table invariant: occupied slots are contiguous from slot0 and contain no duplicates.
- Publish:
  - frame_tick in IDLE: keycode <= table at that edge.
  - frame_tick in SCAN/APPLY: set pending. Publish at the first IDLE cycle after APPLY; the value includes that event; then clear pending.
  - frame_tick in IDLE on the same edge an event is accepted: publishes the pre-event table.
  - keycode is otherwise held.
- key_count reflects the internal table immediately after APPLY, not the published word.
- overflow stays set until clear-all or reset.

Test Plan:
- Reset, then press 0x50, 0x4F, 0x52 with frame_tick after each -> keycode=32'h00524F50, key_count=3, ev_ready low exactly 2 cycles after each accept.
- Press 0x04, 0x07, 0x1A, 0x16, then press 0x2C -> keycode=32'h161A0704, key_count=4, overflow=1; press 0x07 again -> unchanged.
- From 32'h161A0704, release 0x07 then frame_tick -> keycode=32'h00161A04, key_count=3. Release 0x99 -> unchanged.
- Assert frame_tick during SCAN of press 0x50 on an empty table -> keycode stays 0 through APPLY, becomes 32'h00000050 in the next IDLE cycle with no further tick.
- Drive Reset_n=0 during APPLY of a press with 2 keys held -> next cycle keycode=0, key_count=0, overflow=0, ev_ready=1.
- Clear-all after overflow -> overflow=0, key_count=0; published keycode becomes 0 only on the next frame_tick.
